// File: rtl/stream_fifo_pkg.sv
// Shared constants and helpers for the stream_fifo block.
package stream_fifo_pkg;

  localparam int DROP_CNT_W = 16;

  // Level must represent 0..DEPTH inclusive, so one bit wider than a pointer.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stream_fifo_ram.sv
// DEPTH x DATA_W storage for stream_fifo: one synchronous write port and one asynchronous read port.
// The array is never reset; its contents are only meaningful at addresses that hold live words.
module stream_fifo_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [DATA_W-1:0]        i_wr_data,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [DATA_W-1:0]        o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/stream_fifo.sv
// Valid/ready show-ahead FIFO with level, almost-full and a sticky overflow flag.
// Defining STREAM_FIFO_DROP_CNT_EN adds a saturating 16-bit drop_count of refused writes.
module stream_fifo
  import stream_fifo_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = DEPTH - 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [level_w(DEPTH)-1:0]   level,
  output logic                        almost_full,
  output logic                        overflow
`ifdef STREAM_FIFO_DROP_CNT_EN
  , output logic [DROP_CNT_W-1:0]     drop_count
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = level_w(DEPTH);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             r_overflow;

  logic w_push;
  logic w_pop;
  logic w_refuse;

  // Handshake decode uses registered level only, so a same-cycle pop never frees a slot.
  assign in_ready    = (r_level != LVL_W'(DEPTH));
  assign out_valid   = (r_level != '0);
  assign w_push      = in_valid && in_ready;
  assign w_pop       = out_valid && out_ready;
  assign w_refuse    = in_valid && !in_ready;
  assign level       = r_level;
  assign almost_full = (r_level >= LVL_W'(AFULL_LEVEL));
  assign overflow    = r_overflow;

  stream_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (in_data),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (out_data)
  );

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_level <= r_level + LVL_W'(1);
      else if (!w_push && w_pop) r_level <= r_level - LVL_W'(1);
      if (w_refuse) r_overflow <= 1'b1;
    end
  end

`ifdef STREAM_FIFO_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] r_drop_count;

  always_ff @(posedge clk) begin
    if (reset || clear)                     r_drop_count <= '0;
    else if (w_refuse && r_drop_count != '1) r_drop_count <= r_drop_count + DROP_CNT_W'(1);
  end

  assign drop_count = r_drop_count;
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// Directed bench for stream_fifo at DEPTH=4, DATA_W=8, AFULL_LEVEL=2.
module tb_stream_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] level;
  logic       almost_full;
  logic       overflow;
`ifdef STREAM_FIFO_DROP_CNT_EN
  logic [15:0] drop_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stream_fifo #(
    .DATA_W      (8),
    .DEPTH       (4),
    .AFULL_LEVEL (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .level       (level),
    .almost_full (almost_full),
    .overflow    (overflow)
`ifdef STREAM_FIFO_DROP_CNT_EN
    , .drop_count (drop_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_drop(input string tag, input int exp);
`ifdef STREAM_FIFO_DROP_CNT_EN
    chk(tag, 32'(drop_count), 32'(exp));
`else
    if (exp < 0) $display("unused drop check %s", tag);
`endif
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_afull", 32'(almost_full), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk_drop("rst_drop", 0);

    // Fill to full with consumer stalled; almost_full trips at 2 entries.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h11 * 8'(i + 1);
      tick();
      chk("fill_level", 32'(level), 32'(i + 1));
      chk("fill_afull", 32'(almost_full), (i + 1 >= 2) ? 1 : 0);
      chk("fill_head", 32'(out_data), 32'h11);
    end
    chk("full_in_ready", 32'(in_ready), 0);
    in_data = 8'h55;
    tick();
    in_valid = 1'b0;
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_level", 32'(level), 4);
    chk_drop("ovf_drop1", 1);

    // Full with concurrent pop: the write is still refused.
    in_valid = 1'b1; in_data = 8'h66; out_ready = 1'b1;
    chk("drain_d0", 32'(out_data), 32'h11);
    tick();
    in_valid = 1'b0;
    chk("fullpop_level", 32'(level), 3);
    chk_drop("fullpop_drop2", 2);
    for (int i = 1; i < 4; i++) begin
      chk("drain_vld", 32'(out_valid), 1);
      chk("drain_data", 32'(out_data), 32'(8'h11 * 8'(i + 1)));
      tick();
    end
    out_ready = 1'b0;
    chk("drained_vld", 32'(out_valid), 0);
    chk("drained_level", 32'(level), 0);
    chk("drained_ovf", 32'(overflow), 1);

    // Preload two, then eight cycles of push+pop across pointer wrap.
    in_valid = 1'b1;
    in_data = 8'hA0; tick();
    in_data = 8'hA1; tick();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 8'hA2 + 8'(i);
      chk("wrap_pop", 32'(out_data), 32'(8'hA0 + 8'(i)));
      tick();
      chk("wrap_level", 32'(level), 2);
    end
    in_valid = 1'b0;
    chk("wrap_tail0", 32'(out_data), 32'hA8);
    tick();
    chk("wrap_tail1", 32'(out_data), 32'hA9);
    tick();
    chk("wrap_empty", 32'(level), 0);

    // Push into empty with consumer ready: visible only on the next cycle.
    in_valid = 1'b1; in_data = 8'h5A;
    chk("fall_vld0", 32'(out_valid), 0);
    tick();
    in_valid = 1'b0;
    chk("fall_vld1", 32'(out_valid), 1);
    chk("fall_data", 32'(out_data), 32'h5A);
    tick();
    out_ready = 1'b0;
    chk("fall_level", 32'(level), 0);

    // Clear beats a concurrent push.
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'h01 + 8'(i);
      tick();
    end
    chk("pre_clr_level", 32'(level), 3);
    chk("pre_clr_ovf", 32'(overflow), 1);
    clear = 1'b1; in_data = 8'h77;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    chk("clr_level", 32'(level), 0);
    chk("clr_ovf", 32'(overflow), 0);
    chk_drop("clr_drop", 0);
    chk("clr_vld", 32'(out_valid), 0);

    // Reset mid-operation with clear also asserted.
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'h0A + 8'(i);
      tick();
    end
    chk("pre_rst_level", 32'(level), 3);
    reset = 1'b1; clear = 1'b1;
    tick();
    reset = 1'b0; clear = 1'b0; in_valid = 1'b0;
    chk("rst2_level", 32'(level), 0);
    chk("rst2_in_ready", 32'(in_ready), 1);
    chk("rst2_vld", 32'(out_valid), 0);
    chk("rst2_afull", 32'(almost_full), 0);

    // First word after reset comes out intact.
    in_valid = 1'b1; in_data = 8'hC3;
    tick();
    in_valid = 1'b0;
    chk("post_rst_data", 32'(out_data), 32'hC3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stream_fifo.md
STREAM_FIFO -- requirements
Module: stream_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, entry count; must be a power of 2 and >=2.
REQ-003 SHALL have parameter AFULL_LEVEL, default DEPTH-2, almost-full threshold in entries (1..DEPTH).
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port clear  input  1  synchronous flush of contents and flags.
REQ-007 SHALL have port in_valid  input  1  producer offers in_data.
REQ-008 SHALL have port in_ready  output  1  FIFO can accept a word this cycle.
REQ-009 SHALL have port in_data  input  DATA_W  write payload.
REQ-010 SHALL have port out_valid  output  1  out_data holds the oldest stored word.
REQ-011 SHALL have port out_ready  input  1  consumer takes out_data.
REQ-012 SHALL have port out_data  output  DATA_W  oldest stored word, show-ahead.
REQ-013 SHALL have port level  output  $clog2(DEPTH)+1  stored word count, 0..DEPTH inclusive.
REQ-014 SHALL have port almost_full  output  1  level >= AFULL_LEVEL.
REQ-015 SHALL have port overflow  output  1  sticky: a write was refused.

Function
REQ-016 SHALL accept a write ("push") exactly when in_valid && in_ready; in_ready = (level != DEPTH), decoded from registered state only.
REQ-017 SHALL perform a read ("pop") exactly when out_valid && out_ready; out_valid = (level != 0).
REQ-018 SHALL drive out_data combinationally from mem[rd_ptr]; a word pushed into an empty FIFO appears with out_valid=1 on the cycle after acceptance, never the same cycle.
REQ-019 SHALL keep level unchanged on simultaneous push and pop; +1 on push only; -1 on pop only.
REQ-020 SHALL refuse writes while full even if a pop occurs the same cycle; the refused word is discarded and not retried internally.
REQ-021 SHALL advance wr_ptr/rd_ptr modulo DEPTH (natural $clog2(DEPTH)-bit wrap); order is strict FIFO across wrap.
REQ-022 SHALL set overflow on any cycle with in_valid && !in_ready; it stays set until reset or clear.
REQ-023 SHALL, on clear, zero pointers, level and overflow at the next edge; clear has priority over a same-cycle push/pop, which is ignored.
REQ-024 SHALL leave out_data unspecified while out_valid=0.

Reset
REQ-025 SHALL, on the edge with reset=1, zero wr_ptr, rd_ptr, level, overflow (and drop_count when present); reset has priority over clear, push and pop.
REQ-026 SHALL present after reset: in_ready=1, out_valid=0, level=0, almost_full=0 (for AFULL_LEVEL>=1), overflow=0; storage array is not reset.

Configuration
REQ-027 SHALL, with macro STREAM_FIFO_DROP_CNT_EN defined, add output drop_count (16 bits) incrementing on every cycle with in_valid && !in_ready, saturating at 0xFFFF, cleared by reset and clear.
REQ-028 SHALL, without STREAM_FIFO_DROP_CNT_EN, omit the drop_count port and counter; all other behaviour is identical.

Structure
REQ-029 SHALL place in shared package stream_fifo_pkg: DROP_CNT_W=16 and a function computing level width from DEPTH.
REQ-030 SHALL implement storage as sub-module stream_fifo_ram (DEPTH x DATA_W, one synchronous write port, one asynchronous read port).
REQ-031 SHALL keep pointer, level, flag and counter logic in stream_fifo itself.

Verification (DEPTH=4, DATA_W=8, AFULL_LEVEL=2, macro defined)
REQ-032 SHALL cover: push 0x11,0x22,0x33,0x44, out_ready=0 -> level=4, in_ready=0, almost_full=1; offer 0x55 -> overflow=1, drop_count=1, level=4.
REQ-033 SHALL cover: drain after REQ-032 -> out_data 0x11,0x22,0x33,0x44 in order; then out_valid=0, level=0, overflow still 1.
REQ-034 SHALL cover: preload 0xA0,0xA1; then 8 cycles of simultaneous push (0xA2..0xA9) and pop -> level stays 2, popped sequence 0xA0..0xA7 across pointer wrap.
REQ-035 SHALL cover: empty FIFO, push 0x5A with out_ready=1 -> out_valid=0 that cycle, out_valid=1 with out_data=0x5A next cycle, popped, then level=0.
REQ-036 SHALL cover: level=3 with overflow=1, assert clear with concurrent push of 0x77 -> next cycle level=0, overflow=0, drop_count=0, out_valid=0.
REQ-037 SHALL cover: reset mid-operation at level=3, clear=1 concurrently -> next cycle level=0, in_ready=1, out_valid=0, almost_full=0.
